// File: rtl/row_swap_engine.sv
// row_swap_engine
// Services row misses raised by the emulation row cache. On a request it
// optionally writes the dirty victim row (cache slot -> backing store), then
// fetches the requested DRAM row from the backing store into the same slot,
// and pulses sync so the cache FSM can leave its miss state.
//
// Optional feature macro: SWAP_STATS_EN (adds n_wb / n_fetch counters).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, wb             swap request (level), victim dirty flag
//   cRowId              cache slot to refill
//   RowId, VictimRowId  DRAM row to fetch, DRAM row held by the slot
//   sync, busy          completion pulse, swap in progress
//   cm_*                cache memory port (read data one cycle after cm_re)
//   bs_*                backing-store port (req/ready handshake, rvalid data)
//   n_wb, n_fetch       (SWAP_STATS_EN) completed writebacks / swaps, saturating
module row_swap_engine #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 4,
  parameter int DWIDTH    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          wb,
  input  logic [CHWIDTH-1:0]            cRowId,
  input  logic [ADDRWIDTH-1:0]          RowId,
  input  logic [ADDRWIDTH-1:0]          VictimRowId,
  output logic                          sync,
  output logic                          busy,
  output logic [CHWIDTH+COLWIDTH-1:0]   cm_addr,
  output logic                          cm_re,
  output logic                          cm_we,
  output logic [DWIDTH-1:0]             cm_wdata,
  input  logic [DWIDTH-1:0]             cm_rdata,
  output logic                          bs_req,
  output logic                          bs_we,
  output logic [ADDRWIDTH+COLWIDTH-1:0] bs_addr,
  output logic [DWIDTH-1:0]             bs_wdata,
  input  logic                          bs_ready,
  input  logic                          bs_rvalid,
  input  logic [DWIDTH-1:0]             bs_rdata
`ifdef SWAP_STATS_EN
  ,
  output logic [31:0]                   n_wb,
  output logic [31:0]                   n_fetch
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_RD      = 3'd1,
    WB_WR      = 3'd2,
    FETCH_REQ  = 3'd3,
    FETCH_WAIT = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t                 state, state_d;
  logic [COLWIDTH-1:0]    col, col_d;
  logic [CHWIDTH-1:0]     slot_q;
  logic [ADDRWIDTH-1:0]   row_q;
  logic [ADDRWIDTH-1:0]   victim_q;
  logic                   hold_off;
  logic                   accept;
  logic                   take;
  logic                   wb_done;
  logic                   col_max;
  // rd_vld_p1: cm_rdata on the bus this cycle answers last cycle's cm_re
  logic                   rd_vld_p1;
  logic [DWIDTH-1:0]      wb_data_p1;

  assign col_max = &col;

  // Control state: async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      slot_q    <= '0;
      row_q     <= '0;
      victim_q  <= '0;
      hold_off  <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      // A req still high in the cycle right after DONE is stale hold.
      hold_off  <= (state == DONE);
      rd_vld_p1 <= (state == WB_RD);
      if (accept) begin
        slot_q   <= cRowId;
        row_q    <= RowId;
        victim_q <= VictimRowId;
      end
    end
  end

  // Stage p1: capture victim word so bs_wdata stays stable under backpressure
  always_ff @(posedge clk) begin
    if (rd_vld_p1) wb_data_p1 <= cm_rdata;
  end

  always_comb begin
    state_d  = state;
    col_d    = col;
    accept   = 1'b0;
    take     = 1'b0;
    wb_done  = 1'b0;
    sync     = 1'b0;
    cm_addr  = '0;
    cm_re    = 1'b0;
    cm_we    = 1'b0;
    cm_wdata = '0;
    bs_req   = 1'b0;
    bs_we    = 1'b0;
    bs_addr  = '0;
    bs_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req && !hold_off) begin
          accept  = 1'b1;
          col_d   = '0;
          state_d = wb ? WB_RD : FETCH_REQ;
        end
      end
      WB_RD: begin
        cm_re   = 1'b1;
        cm_addr = {slot_q, col};
        state_d = WB_WR;
      end
      WB_WR: begin
        bs_req   = 1'b1;
        bs_we    = 1'b1;
        bs_addr  = {victim_q, col};
        bs_wdata = rd_vld_p1 ? cm_rdata : wb_data_p1;
        if (bs_ready) begin
          if (col_max) begin
            col_d   = '0;
            wb_done = 1'b1;
            state_d = FETCH_REQ;
          end else begin
            col_d   = col + 1'b1;
            state_d = WB_RD;
          end
        end
      end
      FETCH_REQ: begin
        bs_req  = 1'b1;
        bs_addr = {row_q, col};
        if (bs_ready) begin
          // Data returned in the accept cycle is consumed immediately.
          if (bs_rvalid) take = 1'b1;
          else           state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bs_rvalid) take = 1'b1;
      end
      DONE: begin
        sync    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      cm_we    = 1'b1;
      cm_addr  = {slot_q, col};
      cm_wdata = bs_rdata;
      if (col_max) begin
        state_d = DONE;
      end else begin
        col_d   = col + 1'b1;
        state_d = FETCH_REQ;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef SWAP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_wb    <= '0;
      n_fetch <= '0;
    end else begin
      if (wb_done)       n_wb    <= sat_inc(n_wb);
      if (state == DONE) n_fetch <= sat_inc(n_fetch);
    end
  end
`endif

endmodule

// File: tb/tb_row_swap_engine.sv
// Testbench for row_swap_engine: bench-side cache and backing-store models,
// a transaction-level expectation model built per swap, and one compare
// process checking every handshake, cache write and sync pulse.
module tb_row_swap_engine;
  localparam int CHW = 5, AW = 17, CW = 4, DW = 64, NCOL = 16;

  logic           clk, rst_n, req, wb;
  logic [CHW-1:0] cRowId;
  logic [AW-1:0]  RowId, VictimRowId;
  logic           sync, busy, cm_re, cm_we, bs_req, bs_we, bs_ready, bs_rvalid;
  logic [CHW+CW-1:0] cm_addr;
  logic [DW-1:0]  cm_wdata, cm_rdata, bs_wdata, bs_rdata;
  logic [AW+CW-1:0] bs_addr;
`ifdef SWAP_STATS_EN
  logic [31:0] n_wb, n_fetch;
`endif

  row_swap_engine #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wb(wb), .cRowId(cRowId), .RowId(RowId),
    .VictimRowId(VictimRowId), .sync(sync), .busy(busy), .cm_addr(cm_addr),
    .cm_re(cm_re), .cm_we(cm_we), .cm_wdata(cm_wdata), .cm_rdata(cm_rdata),
    .bs_req(bs_req), .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
    .bs_ready(bs_ready), .bs_rvalid(bs_rvalid), .bs_rdata(bs_rdata)
`ifdef SWAP_STATS_EN
    , .n_wb(n_wb), .n_fetch(n_fetch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW+CW-1:0] addr; logic [DW-1:0] data; } bs_t;
  typedef struct { logic [CHW+CW-1:0] addr; logic [DW-1:0] data; } cm_t;

  logic [DW-1:0] cmem [0:(1<<CHW)-1][0:NCOL-1];
  bs_t exp_bs[$], obs_bs[$];
  cm_t exp_cm[$], obs_cm[$];
  int  n_cmp = 0, n_fail = 0, sync_cnt = 0;

  // backing-store behaviour knobs
  int  bs_wait = 0;
  bit  same_cyc = 0, noise = 0;

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] r, input logic [CW-1:0] c);
    return {16'hBEEF, 15'h0, r, 12'h0, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responders: drive at +2 after the edge, record at the falling edge.
  bit               pend = 0, prev_re = 0;
  int               waitcnt = 0;
  logic [AW+CW-1:0] pend_addr;
  logic [CHW+CW-1:0] prev_re_addr;
  always begin
    @(posedge clk); #2;
    bs_rvalid = 1'b0;
    bs_rdata  = {$urandom, $urandom};
    cm_rdata  = prev_re ? cmem[prev_re_addr[CHW+CW-1:CW]][prev_re_addr[CW-1:0]]
                        : {$urandom, $urandom};
    if (pend) begin
      bs_rvalid = 1'b1;
      bs_rdata  = fdat(pend_addr[AW+CW-1:CW], pend_addr[CW-1:0]);
      pend      = 0;
    end
    bs_ready = 1'b0;
    if (bs_req) begin
      if (waitcnt < bs_wait) waitcnt++;
      else begin bs_ready = 1'b1; waitcnt = 0; end
    end
    if (bs_ready && !bs_we && same_cyc) begin
      bs_rvalid = 1'b1;
      bs_rdata  = fdat(bs_addr[AW+CW-1:CW], bs_addr[CW-1:0]);
    end else if (noise && bs_req && bs_we) begin
      bs_rvalid = 1'b1;
    end
    @(negedge clk);
    if (!rst_n) begin
      pend = 0; waitcnt = 0; prev_re = 0;
    end else begin
      if (bs_req && bs_ready && !bs_we && !same_cyc) begin
        pend = 1; pend_addr = bs_addr;
      end
      if (cm_we) cmem[cm_addr[CHW+CW-1:CW]][cm_addr[CW-1:0]] = cm_wdata;
      prev_re = cm_re; prev_re_addr = cm_addr;
    end
  end

  // Compare process
  bit               stall_prev = 0;
  logic [AW+CW-1:0] sv_addr;
  logic [DW-1:0]    sv_wdata;
  logic             sv_we;
  bs_t              eb;
  cm_t              ec;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stable_req", bs_req, 1);
        chk("stable_we", bs_we, sv_we);
        chk("stable_addr", bs_addr, sv_addr);
        chk("stable_wdata", bs_wdata, sv_wdata);
      end
      if (bs_req && bs_ready) begin
        obs_bs.push_back('{bs_we, bs_addr, bs_wdata});
        if (exp_bs.size() == 0) chk("bs_unexpected", bs_addr, '1);
        else begin
          eb = exp_bs.pop_front();
          chk("bs_we", bs_we, eb.we);
          chk("bs_addr", bs_addr, eb.addr);
          if (eb.we) chk("bs_wdata", bs_wdata, eb.data);
        end
      end
      if (cm_we) begin
        obs_cm.push_back('{cm_addr, cm_wdata});
        if (exp_cm.size() == 0) chk("cm_unexpected", cm_addr, '1);
        else begin
          ec = exp_cm.pop_front();
          chk("cm_addr", cm_addr, ec.addr);
          chk("cm_wdata", cm_wdata, ec.data);
        end
      end
      if (sync) begin
        sync_cnt++;
        chk("sync_busy", busy, 1);
        chk("sync_bs_left", exp_bs.size(), 0);
        chk("sync_cm_left", exp_cm.size(), 0);
      end
      stall_prev = bs_req && !bs_ready;
      sv_we = bs_we; sv_addr = bs_addr; sv_wdata = bs_wdata;
    end
  end

  // Expected transactions of one swap, from the cache contents at accept
  task automatic build_model(input logic [CHW-1:0] s, input logic [AW-1:0] r,
                             input logic [AW-1:0] v, input logic w);
    for (int c = 0; c < NCOL; c++)
      if (w) exp_bs.push_back('{1'b1, {v, CW'(c)}, cmem[s][c]});
    for (int c = 0; c < NCOL; c++) begin
      exp_bs.push_back('{1'b0, {r, CW'(c)}, '0});
      exp_cm.push_back('{{s, CW'(c)}, fdat(r, CW'(c))});
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sync"}, sync, 0);      chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cm_re"}, cm_re, 0);    chk({tag, "_cm_we"}, cm_we, 0);
    chk({tag, "_cm_addr"}, cm_addr, 0); chk({tag, "_cm_wdata"}, cm_wdata, 0);
    chk({tag, "_bs_req"}, bs_req, 0);  chk({tag, "_bs_we"}, bs_we, 0);
    chk({tag, "_bs_addr"}, bs_addr, 0); chk({tag, "_bs_wdata"}, bs_wdata, 0);
  endtask

  // Run one swap; lat = cycles from accept cycle to sync cycle inclusive
  task automatic do_swap(input logic [CHW-1:0] s, input logic [AW-1:0] r,
                         input logic [AW-1:0] v, input logic w, input bit chg,
                         output int lat);
    @(posedge clk); #1;
    cRowId = s; RowId = r; VictimRowId = v; wb = w; req = 1'b1;
    build_model(s, r, v, w);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (chg && lat == 5) begin
        RowId = 17'h00001; cRowId = '0; VictimRowId = '0; wb = 1'b1;
      end
      if (sync) break;
      if (lat > 3000) begin
        chk("sync_timeout", lat, 0);
        break;
      end
    end
    @(posedge clk); #1;          // req kept high in the cycle after DONE
    @(negedge clk); chk("post_sync_busy", busy, 0);
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); chk("stale_req_ignored", busy, 0);
  endtask

  int lat, b, s0, base_cm;

  initial begin
    rst_n = 1'b0; req = 1'b0; wb = 1'b0; cRowId = '0; RowId = '0; VictimRowId = '0;
    bs_ready = 1'b0; bs_rvalid = 1'b0; bs_rdata = '0; cm_rdata = '0;
    for (int i = 0; i < (1 << CHW); i++)
      for (int c = 0; c < NCOL; c++)
        cmem[i][c] = (i == 31) ? DW'(c) : {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk); check_idle("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // Clean fetch
    b = obs_bs.size(); base_cm = obs_cm.size();
    do_swap(5'd3, 17'h000A5, 17'h0, 1'b0, 0, lat);
    chk("clean_latency", lat, 34);
    chk("clean_first_rd", obs_bs[b].addr, 21'h00A50);
    chk("clean_last_rd", obs_bs[b+15].addr, 21'h00A5F);
    chk("clean_last_cm_addr", obs_cm[base_cm+15].addr, 9'h03F);
    chk("clean_last_cm_data", obs_cm[base_cm+15].data, 64'hBEEF_0000_00A5_000F);
    chk("clean_sync_cnt", sync_cnt, 1);

    // Dirty swap with stray rvalid during writeback
    noise = 1;
    b = obs_bs.size();
    do_swap(5'd31, 17'h00042, 17'h1FFFF, 1'b1, 0, lat);
    noise = 0;
    chk("dirty_first_wr_addr", obs_bs[b].addr, 21'h1FFFF0);
    chk("dirty_first_wr_data", obs_bs[b].data, 64'd0);
    chk("dirty_last_wr_addr", obs_bs[b+15].addr, 21'h1FFFFF);
    chk("dirty_last_wr_data", obs_bs[b+15].data, 64'd15);
    chk("dirty_first_rd_we", obs_bs[b+16].we, 0);
    chk("dirty_first_rd_addr", obs_bs[b+16].addr, 21'h00420);

    // Backpressure: 3 wait cycles on every request
    bs_wait = 3;
    do_swap(5'd5, 17'h0ABCD, 17'h12345, 1'b1, 0, lat);
    bs_wait = 0;
    chk("bp_sync_cnt", sync_cnt, 3);

    // Inputs changed after accept
    b = obs_bs.size();
    do_swap(5'd7, 17'h00F00, 17'h0, 1'b0, 1, lat);
    chk("chg_rd_count", obs_bs.size() - b, 16);
    chk("chg_last_rd", obs_bs[obs_bs.size()-1].addr, 21'h00F00F);
    chk("chg_last_cm", obs_cm[obs_cm.size()-1].addr, 9'h07F);

    // Ready and rvalid in the same cycle
    same_cyc = 1;
    do_swap(5'd9, 17'h00155, 17'h0, 1'b0, 0, lat);
    same_cyc = 0;
    chk("samecyc_latency", lat, 18);
`ifdef SWAP_STATS_EN
    chk("stats_n_wb", n_wb, 2);
    chk("stats_n_fetch", n_fetch, 5);
`endif

    // Reset mid-fetch
    s0 = sync_cnt; base_cm = obs_cm.size();
    @(posedge clk); #1;
    cRowId = 5'd2; RowId = 17'h00777; wb = 1'b0; req = 1'b1;
    build_model(5'd2, 17'h00777, 17'h0, 1'b0);
    lat = 0;
    while (obs_cm.size() - base_cm < 7 && lat < 500) begin @(negedge clk); lat++; end
    chk("mid_cols_written", obs_cm.size() - base_cm, 7);
    @(posedge clk); #1; rst_n = 1'b0; req = 1'b0;
    @(negedge clk); check_idle("midreset");
    exp_bs.delete(); exp_cm.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_sync", sync_cnt, s0);
`ifdef SWAP_STATS_EN
    chk("midreset_n_fetch", n_fetch, 0);
`endif
    b = obs_bs.size();
    do_swap(5'd2, 17'h00888, 17'h0, 1'b0, 0, lat);
    chk("restart_first_rd", obs_bs[b].addr, 21'h008880);
    chk("restart_sync_cnt", sync_cnt, s0 + 1);
`ifdef SWAP_STATS_EN
    chk("restart_n_wb", n_wb, 0);
    chk("restart_n_fetch", n_fetch, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
